// File: rtl/dpi_int_pkg.sv
// dpi_int_pkg: shared request/delivery types and eject FSM states for the SynFull NE adapter
package dpi_int_pkg;
  localparam int DEST_W = 8;
  localparam int SIZE_W = 8;
  localparam int SRC_W = 8;
  localparam int PKT_ID_W = 32;
  typedef struct packed {
    logic valid;
    logic [DEST_W-1:0] dest;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0] src;
    logic [PKT_ID_W-1:0] id;
  } req_t;
  typedef struct packed {
    logic valid;
    logic [PKT_ID_W-1:0] id;
  } deliver_t;
  typedef enum logic {IDLE, IN_PKT} ej_state_t;
endpackage

// File: rtl/synfull_req_fifo.sv
// synfull_req_fifo: synchronous FIFO of req_t with async active-low reset
// ports: clk_i, rst_i (async, active-low), push_i/din_i write, pop_i read,
//        dout_o head entry, full_o/empty_o flags, count_o occupancy
module synfull_req_fifo
  import dpi_int_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  req_t                     din_i,
  output req_t                     dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  req_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign full_o = r_cnt == (AW+1)'(DEPTH);
  assign empty_o = r_cnt == '0;
  assign count_o = r_cnt;
  assign dout_o = r_mem[r_rd];
  assign w_push = push_i & ~full_o;
  assign w_pop = pop_i & ~empty_o;
  always_ff @(posedge clk_i) if (w_push) r_mem[r_wr] <= din_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/synfull_ne_adapter.sv
// synfull_ne_adapter: per-endpoint bridge between the SynFull DPI stage and one ProNoC NI
// ports: clk_i, rst_i (async, active-low); req_i/ready_o from DPI stage;
//        ni_valid_o/ni_ready_i/ni_dest_o/ni_size_o/ni_id_o toward NI;
//        flit_valid_i/flit_hdr_i/flit_tail_i/flit_id_i ejected flits;
//        deliver_o one-cycle delivery pulse; err_o sticky framing error;
//        inj_cnt_o/del_cnt_o injected/delivered packet counters
module synfull_ne_adapter
  import dpi_int_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  req_t              req_i,
  output logic              ready_o,
  output logic              ni_valid_o,
  input  logic              ni_ready_i,
  output logic [DEST_W-1:0] ni_dest_o,
  output logic [SIZE_W-1:0] ni_size_o,
  output logic [ID_W-1:0]   ni_id_o,
  input  logic              flit_valid_i,
  input  logic              flit_hdr_i,
  input  logic              flit_tail_i,
  input  logic [ID_W-1:0]   flit_id_i,
  output deliver_t          deliver_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  inj_cnt_o,
  output logic [CNT_W-1:0]  del_cnt_o
);
  req_t w_head;
  logic w_full, w_empty, w_push, w_pop, w_done, w_unused;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic [PKT_ID_W-1:0] w_del_id;
  ej_state_t r_state;
  logic [PKT_ID_W-1:0] r_id;
  deliver_t r_del;
  logic r_err;
  logic [CNT_W-1:0] r_inj, r_dcnt;
  assign ready_o = ~w_full;
  assign ni_valid_o = ~w_empty;
  assign w_push = req_i.valid & ready_o;
  assign w_pop = ni_valid_o & ni_ready_i;
  assign ni_dest_o = w_head.dest;
  assign ni_size_o = w_head.size;
  assign ni_id_o = ID_W'(w_head.id);
  assign w_unused = ^{w_head.valid, w_head.src, w_count};
  synfull_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_push), .pop_i(w_pop), .din_i(req_i),
    .dout_o(w_head), .full_o(w_full), .empty_o(w_empty), .count_o(w_count)
  );
  // a header always restarts framing; a bare tail only completes inside a packet
  assign w_done = flit_valid_i & flit_tail_i & (flit_hdr_i | r_state == IN_PKT);
  assign w_del_id = flit_hdr_i ? PKT_ID_W'(flit_id_i) : r_id;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_state <= IDLE;
      r_id <= '0;
      r_del <= '0;
      r_err <= 1'b0;
      r_inj <= '0;
      r_dcnt <= '0;
    end else begin
      r_del <= '{valid: w_done, id: w_done ? w_del_id : '0};
      r_inj <= r_inj + CNT_W'(w_pop);
      r_dcnt <= r_dcnt + CNT_W'(w_done);
      if (flit_valid_i) begin
        if (flit_hdr_i) begin
          if (r_state == IN_PKT) r_err <= 1'b1;
          r_id <= PKT_ID_W'(flit_id_i);
          r_state <= flit_tail_i ? IDLE : IN_PKT;
        end else if (r_state == IDLE) r_err <= 1'b1;
        else if (flit_tail_i) r_state <= IDLE;
      end
    end
  assign deliver_o = r_del;
  assign err_o = r_err;
  assign inj_cnt_o = r_inj;
  assign del_cnt_o = r_dcnt;
endmodule

// File: tb/tb_synfull_ne_adapter.sv
// tb_synfull_ne_adapter: directed self-checking bench for synfull_ne_adapter
module tb_synfull_ne_adapter;
  import dpi_int_pkg::*;
  logic clk_i = 0, rst_i = 0;
  req_t req_i = '0;
  logic ni_ready_i = 0, flit_valid_i = 0, flit_hdr_i = 0, flit_tail_i = 0;
  logic [31:0] flit_id_i = 0;
  logic ready_o, ni_valid_o, err_o;
  logic [7:0] ni_dest_o, ni_size_o;
  logic [31:0] ni_id_o, inj_cnt_o, del_cnt_o;
  deliver_t deliver_o;
  int checks = 0, failures = 0;
  synfull_ne_adapter dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .ready_o(ready_o),
    .ni_valid_o(ni_valid_o), .ni_ready_i(ni_ready_i), .ni_dest_o(ni_dest_o),
    .ni_size_o(ni_size_o), .ni_id_o(ni_id_o), .flit_valid_i(flit_valid_i),
    .flit_hdr_i(flit_hdr_i), .flit_tail_i(flit_tail_i), .flit_id_i(flit_id_i),
    .deliver_o(deliver_o), .err_o(err_o), .inj_cnt_o(inj_cnt_o), .del_cnt_o(del_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic v, input logic [31:0] id);
    req_i = '{valid: v, dest: 8'd3, size: 8'd4, src: 8'd1, id: id};
  endtask
  task automatic flit(input logic v, input logic h, input logic t, input logic [31:0] id);
    flit_valid_i = v; flit_hdr_i = h; flit_tail_i = t; flit_id_i = id;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_nivalid"}, 64'(ni_valid_o), 64'd0);
    chk({tag, "_deliver"}, 64'(deliver_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_inj"}, 64'(inj_cnt_o), 64'd0);
    chk({tag, "_del"}, 64'(del_cnt_o), 64'd0);
  endtask
  initial begin
    #2;
    chk_reset("rst");
    tick(); tick();
    rst_i = 1;
    // 1: single request through an always-ready NI
    ni_ready_i = 1; req(1, 5);
    tick();
    req(0, 0);
    chk("t1_valid", 64'(ni_valid_o), 64'd1);
    chk("t1_id", 64'(ni_id_o), 64'd5);
    chk("t1_dest", 64'(ni_dest_o), 64'd3);
    chk("t1_size", 64'(ni_size_o), 64'd4);
    tick();
    chk("t1_inj", 64'(inj_cnt_o), 64'd1);
    chk("t1_empty", 64'(ni_valid_o), 64'd0);
    // 2: fill while NI stalls, extra push ignored, drain in order
    ni_ready_i = 0;
    for (int i = 1; i <= 4; i++) begin
      req(1, 32'(i));
      tick();
    end
    chk("t2_full", 64'(ready_o), 64'd0);
    req(1, 99);
    tick();
    req(0, 0);
    chk("t2_still_full", 64'(ready_o), 64'd0);
    ni_ready_i = 1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t2_pop%0d", i), 64'(ni_id_o), 64'(i));
      tick();
    end
    chk("t2_drained", 64'(ni_valid_o), 64'd0);
    chk("t2_inj", 64'(inj_cnt_o), 64'd5);
    // 3: full FIFO with simultaneous pop and push: push rejected
    ni_ready_i = 0;
    for (int i = 11; i <= 14; i++) begin
      req(1, 32'(i));
      tick();
    end
    chk("t3_full", 64'(ready_o), 64'd0);
    ni_ready_i = 1; req(1, 15);
    tick();
    req(0, 0); ni_ready_i = 0;
    chk("t3_ready", 64'(ready_o), 64'd1);
    chk("t3_head", 64'(ni_id_o), 64'd12);
    ni_ready_i = 1;
    for (int i = 12; i <= 14; i++) begin
      chk($sformatf("t3_pop%0d", i), 64'(ni_id_o), 64'(i));
      tick();
    end
    chk("t3_count3", 64'(ni_valid_o), 64'd0);
    chk("t3_inj", 64'(inj_cnt_o), 64'd9);
    ni_ready_i = 0;
    // 4: multi-flit packet
    flit(1, 1, 0, 9);
    tick();
    chk("t4_hdr_nopulse", 64'(deliver_o.valid), 64'd0);
    flit(1, 0, 0, 0);
    tick();
    chk("t4_body_nopulse", 64'(deliver_o.valid), 64'd0);
    flit(1, 0, 1, 0);
    tick();
    flit(0, 0, 0, 0);
    chk("t4_pulse", 64'(deliver_o), {31'd0, 1'b1, 32'd9});
    chk("t4_delcnt", 64'(del_cnt_o), 64'd1);
    tick();
    chk("t4_pulse_end", 64'(deliver_o.valid), 64'd0);
    // 5: back-to-back single-flit packets
    flit(1, 1, 1, 7);
    tick();
    chk("t5_pulse7", 64'(deliver_o), {31'd0, 1'b1, 32'd7});
    flit(1, 1, 1, 8);
    tick();
    flit(0, 0, 0, 0);
    chk("t5_pulse8", 64'(deliver_o), {31'd0, 1'b1, 32'd8});
    tick();
    chk("t5_end", 64'(deliver_o.valid), 64'd0);
    chk("t5_delcnt", 64'(del_cnt_o), 64'd3);
    chk("t5_noerr", 64'(err_o), 64'd0);
    // 6: tail in IDLE, then reset mid-packet with a queued request
    flit(1, 0, 1, 0);
    tick();
    chk("t6_err", 64'(err_o), 64'd1);
    chk("t6_nopulse", 64'(deliver_o.valid), 64'd0);
    chk("t6_delcnt", 64'(del_cnt_o), 64'd3);
    flit(1, 1, 0, 20); req(1, 33);
    tick();
    flit(0, 0, 0, 0); req(0, 0);
    chk("t6_queued", 64'(ni_valid_o), 64'd1);
    #2 rst_i = 0;
    #1;
    chk_reset("t6_rst");
    tick();
    rst_i = 1;
    flit(1, 0, 1, 0);
    tick();
    flit(0, 0, 0, 0);
    chk("t6_dropped_nopulse", 64'(deliver_o.valid), 64'd0);
    chk("t6_dropped_err", 64'(err_o), 64'd1);
    // header inside a packet: error, restart with the new id
    rst_i = 0;
    tick();
    rst_i = 1;
    flit(1, 1, 0, 40);
    tick();
    chk("t7_noerr", 64'(err_o), 64'd0);
    flit(1, 1, 1, 41);
    tick();
    flit(0, 0, 0, 0);
    chk("t7_pulse41", 64'(deliver_o), {31'd0, 1'b1, 32'd41});
    chk("t7_err", 64'(err_o), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
